// File: rtl/ram_responder.sv
// Word-organised RAM responder with programmable wait states.
// Answers the requester's Ren/Wen handshake through an IDLE/WAIT/ACK sequence.
module ram_responder #(
  parameter int unsigned ADDR_W   = 10,
  parameter int unsigned LATENCY  = 2,
  parameter logic [31:0] OOR_DATA = 32'hBAD1BAD1
) (
  input  logic        CLK,
  input  logic        nRST,
  input  logic        Ren,
  input  logic        Wen,
  input  logic [31:0] ramaddr,
  input  logic [31:0] ramstore,
  output logic [31:0] ramload,
  output logic        busy_o
);

  localparam int unsigned DEPTH = 1 << ADDR_W;
  localparam logic [3:0] CNT_INIT = 4'(LATENCY - 1);

  if (LATENCY < 1 || LATENCY > 15) begin : g_bad_latency
    $error("ram_responder: LATENCY must be 1..15");
  end

  if (ADDR_W < 1 || ADDR_W > 29) begin : g_bad_addr_w
    $error("ram_responder: ADDR_W must be 1..29");
  end

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_WAIT = 2'd1,
    S_ACK  = 2'd2
  } state_t;

  state_t              r_state;
  logic [3:0]          r_cnt;
  logic                r_wr;
  logic                r_oor;
  logic [ADDR_W-1:0]   r_idx;
  logic [31:0]         r_data;
  logic [31:0]         r_load;
  logic [31:0]         r_mem [DEPTH];

  logic                w_req;
  logic                w_commit;
  logic                w_oor_in;
  logic [ADDR_W-1:0]   w_idx_in;
  logic                w_unused_addr;

  assign w_req         = Ren | Wen;
  assign w_commit      = (r_state == S_WAIT) && (r_cnt == 4'd0);
  assign w_oor_in      = |ramaddr[31:ADDR_W+2];
  assign w_idx_in      = ramaddr[ADDR_W+1:2];
  assign w_unused_addr = ^ramaddr[1:0];

  // Busy in IDLE is combinational so a new request stalls immediately.
  always_comb begin
    busy_o = 1'b0;
    unique case (r_state)
      S_IDLE:  busy_o = w_req;
      S_WAIT:  busy_o = 1'b1;
      default: busy_o = 1'b0;
    endcase
  end

  always_ff @(posedge CLK or negedge nRST) begin
    if (!nRST) begin
      r_state <= S_IDLE;
      r_cnt   <= 4'd0;
      r_wr    <= 1'b0;
      r_oor   <= 1'b0;
      r_idx   <= '0;
      r_data  <= 32'h0;
      r_load  <= 32'h0;
    end else begin
      unique case (r_state)
        S_IDLE: begin
          if (w_req) begin
            r_wr    <= Wen;
            r_oor   <= w_oor_in;
            r_idx   <= w_idx_in;
            r_data  <= ramstore;
            r_cnt   <= CNT_INIT;
            r_state <= S_WAIT;
          end
        end
        S_WAIT: begin
          if (r_cnt != 4'd0) begin
            r_cnt <= r_cnt - 4'd1;
          end else begin
            if (!r_wr) begin
              r_load <= r_oor ? OOR_DATA : r_mem[r_idx];
            end
            r_state <= S_ACK;
          end
        end
        S_ACK: begin
          r_state <= S_IDLE;
        end
        default: begin
          r_state <= S_IDLE;
        end
      endcase
    end
  end

  // Array is not reset; a reset in WAIT leaves r_state IDLE so no commit.
  always_ff @(posedge CLK) begin
    if (w_commit && r_wr && !r_oor) begin
      r_mem[r_idx] <= r_data;
    end
  end

  assign ramload = r_load;

endmodule

// File: tb/tb_ram_responder.sv
// Self-checking bench for ram_responder.
// Transaction-level memory model plus cycle-exact handshake checks.
module tb_ram_responder;

  localparam int unsigned AW  = 10;
  localparam int unsigned LAT = 2;
  localparam logic [31:0] OOR = 32'hBAD1BAD1;

  logic        CLK;
  logic        nRST;
  logic        Ren;
  logic        Wen;
  logic [31:0] ramaddr;
  logic [31:0] ramstore;
  logic [31:0] ramload;
  logic        busy_o;

  int vectors;
  int errors;

  logic [31:0] m_mem [int];
  logic [31:0] m_load;
  int          written [$];

  ram_responder #(
    .ADDR_W  (AW),
    .LATENCY (LAT),
    .OOR_DATA(OOR)
  ) dut (
    .CLK     (CLK),
    .nRST    (nRST),
    .Ren     (Ren),
    .Wen     (Wen),
    .ramaddr (ramaddr),
    .ramstore(ramstore),
    .ramload (ramload),
    .busy_o  (busy_o)
  );

  initial CLK = 1'b0;
  always #5 CLK = ~CLK;

  function automatic bit in_range(input logic [31:0] a);
    longint unsigned lim;
    lim = 64'd1 << (AW + 2);
    return longint'(a) < lim;
  endfunction

  function automatic int idx_of(input logic [31:0] a);
    return int'((a / 4) % (32'd1 << AW));
  endfunction

  // One full transaction, entered and left at a negedge with the DUT in IDLE.
  task automatic access(input logic ren, input logic wen,
                        input logic [31:0] addr, input logic [31:0] data);
    logic [31:0] exp_load;
    int          idx;
    idx      = idx_of(addr);
    exp_load = m_load;
    if (wen) begin
      if (in_range(addr)) begin
        if (!m_mem.exists(idx)) written.push_back(idx);
        m_mem[idx] = data;
      end
    end else if (ren) begin
      exp_load = in_range(addr) ? m_mem[idx] : OOR;
    end
    Ren      = ren;
    Wen      = wen;
    ramaddr  = addr;
    ramstore = data;
    for (int c = 0; c <= int'(LAT); c++) begin
      #1;
      vectors++;
      if (busy_o !== 1'b1)
        $display("FAIL busy_wait c=%0d addr=%h: got %b expected 1", c, addr, busy_o);
      if (busy_o !== 1'b1) errors++;
      vectors++;
      if (ramload !== m_load) begin
        $display("FAIL load_hold c=%0d: got %h expected %h", c, ramload, m_load);
        errors++;
      end
      @(negedge CLK);
      Ren      = 1'($urandom);
      Wen      = 1'($urandom);
      ramaddr  = $urandom;
      ramstore = $urandom;
    end
    Ren    = 1'b0;
    Wen    = 1'b0;
    m_load = exp_load;
    #1;
    vectors++;
    if (busy_o !== 1'b0) begin
      $display("FAIL busy_ack addr=%h: got %b expected 0", addr, busy_o);
      errors++;
    end
    vectors++;
    if (ramload !== m_load) begin
      $display("FAIL load_ack addr=%h r=%b w=%b: got %h expected %h",
               addr, ren, wen, ramload, m_load);
      errors++;
    end
    @(negedge CLK);
  endtask

  task automatic test_reset();
    nRST = 1'b0;
    Ren = 1'b0; Wen = 1'b0; ramaddr = '0; ramstore = '0;
    m_load = 32'h0;
    @(negedge CLK);
    #1;
    vectors++;
    if (busy_o !== 1'b0) begin
      $display("FAIL reset_busy: got %b expected 0", busy_o);
      errors++;
    end
    vectors++;
    if (ramload !== 32'h0) begin
      $display("FAIL reset_load: got %h expected 0", ramload);
      errors++;
    end
    Ren = 1'b1;
    #1;
    vectors++;
    if (busy_o !== 1'b1) begin
      $display("FAIL reset_busy_ren: got %b expected 1", busy_o);
      errors++;
    end
    Ren = 1'b0;
    @(negedge CLK);
    nRST = 1'b1;
    @(negedge CLK);
  endtask

  task automatic test_basic();
    access(1'b0, 1'b1, 32'h00000010, 32'h12341234);
    access(1'b1, 1'b0, 32'h00000010, 32'h0);
  endtask

  task automatic test_out_of_range();
    access(1'b0, 1'b1, 32'h00000678, 32'hCAFEF00D);
    access(1'b1, 1'b0, 32'habcdabcd, 32'h0);
    access(1'b0, 1'b1, 32'h56785678, 32'h99999999);
    access(1'b1, 1'b0, 32'h00000678, 32'h0);
  endtask

  task automatic test_both_high();
    access(1'b1, 1'b0, 32'h00000010, 32'h0);
    access(1'b1, 1'b1, 32'h00000008, 32'h33333333);
    access(1'b1, 1'b0, 32'h00000008, 32'h0);
  endtask

  task automatic test_back_to_back();
    logic [31:0] exp_busy;
    logic [31:0] prev;
    access(1'b0, 1'b1, 32'h0, $urandom);
    access(1'b0, 1'b1, 32'h4, $urandom);
    exp_busy = 32'b01110111;
    prev     = m_load;
    Ren = 1'b1; Wen = 1'b0; ramaddr = 32'h0; ramstore = $urandom;
    for (int c = 0; c < 8; c++) begin
      logic [31:0] exp_l;
      if (c == 3) ramaddr = 32'h4;
      if (c == 7) Ren = 1'b0;
      exp_l = (c < 3) ? prev : (c < 7) ? m_mem[0] : m_mem[1];
      #1;
      vectors++;
      if (busy_o !== exp_busy[c]) begin
        $display("FAIL b2b_busy c=%0d: got %b expected %b", c, busy_o, exp_busy[c]);
        errors++;
      end
      vectors++;
      if (ramload !== exp_l) begin
        $display("FAIL b2b_load c=%0d: got %h expected %h", c, ramload, exp_l);
        errors++;
      end
      @(negedge CLK);
    end
    m_load = m_mem[1];
  endtask

  task automatic test_reset_mid();
    access(1'b0, 1'b1, 32'h00000020, 32'h11111111);
    access(1'b1, 1'b0, 32'h00000020, 32'h0);
    Ren = 1'b0; Wen = 1'b1; ramaddr = 32'h20; ramstore = 32'h22222222;
    @(negedge CLK);
    Wen = 1'b0;
    #2;
    nRST = 1'b0;
    m_load = 32'h0;
    #1;
    vectors++;
    if (busy_o !== 1'b0) begin
      $display("FAIL midrst_busy: got %b expected 0", busy_o);
      errors++;
    end
    vectors++;
    if (ramload !== 32'h0) begin
      $display("FAIL midrst_load: got %h expected 0", ramload);
      errors++;
    end
    @(negedge CLK);
    nRST = 1'b1;
    @(negedge CLK);
    access(1'b1, 1'b0, 32'h00000020, 32'h0);
  endtask

  task automatic test_random();
    for (int n = 0; n < 80; n++) begin
      int          kind;
      logic [31:0] a;
      kind = $urandom_range(0, 4);
      if (kind == 1 && written.size() == 0) kind = 0;
      unique case (kind)
        0: begin
          a = {20'h0, 10'($urandom), 2'($urandom)};
          access(1'b0, 1'b1, a, $urandom);
        end
        1: begin
          a = (written[$urandom_range(0, written.size() - 1)] << 2) | 32'($urandom_range(0, 3));
          access(1'b1, 1'b0, a, $urandom);
        end
        2: begin
          a = $urandom | (32'd1 << (AW + 2));
          access(1'b1, 1'b0, a, $urandom);
        end
        3: begin
          a = $urandom | (32'd1 << (AW + 2));
          access(1'($urandom), 1'b1, a, $urandom);
        end
        default: begin
          a = {20'h0, 10'($urandom), 2'($urandom)};
          access(1'b1, 1'b1, a, $urandom);
        end
      endcase
    end
  endtask

  initial begin
    vectors = 0;
    errors  = 0;
    test_reset();
    test_basic();
    test_out_of_range();
    test_both_high();
    test_back_to_back();
    test_reset_mid();
    test_random();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
    $finish;
  end

endmodule
